psum_accum: RTL and testbench
=============================

PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 Parameter psum_bw, 16, width of partial sums arriving from a MAC column's out_s and of out_data.
REQ-002 Parameter depth, 16, number of accumulation entries; power of two, at least 2.
REQ-003 Parameter aw, log2(depth), address width.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port acc_start  input  1  one-cycle pulse that begins a new tile and invalidates all entries.
REQ-007 Port in_valid  input  1  in_psum and in_addr are valid this cycle.
REQ-008 Port in_psum  input  psum_bw  signed partial sum from the column bottom.
REQ-009 Port in_addr  input  aw  target entry for in_psum.
REQ-010 Port drain_start  input  1  one-cycle pulse that ends accumulation and starts readout.
REQ-011 Port relu_en  input  1  clamp negative results to 0 on readout; sampled each drain beat.
REQ-012 Port out_data  output  psum_bw  signed drained entry value.
REQ-013 Port out_valid  output  1  out_data is valid.
REQ-014 Port out_ready  input  1  consumer accepts out_data.
REQ-015 Port busy  output  1  high in ACCUM or DRAIN.
REQ-016 Port done  output  1  one-cycle pulse after the last drain handshake.

Function
REQ-017 FSM states: IDLE, ACCUM, DRAIN.
REQ-018 IDLE: acc_start -> ACCUM and clear all per-entry written flags; drain_start and in_valid are ignored.
REQ-019 ACCUM: in_valid writes mem[in_addr] = in_psum if the entry is unwritten, else sat(mem[in_addr] + in_psum), and sets its written flag, with single-cycle read-modify-write.
REQ-020 Back-to-back in_valid to the same address accumulates every beat; no hazard stall.
REQ-021 Sum is formed at psum_bw+1 bits and saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-022 ACCUM: drain_start -> DRAIN with ptr=0; in_valid in the same cycle is still written, and is visible in the drained value.
REQ-023 ACCUM: acc_start again clears the written flags and stays in ACCUM; it takes priority over drain_start.
REQ-024 DRAIN: out_valid=1; out_data = relu_en ? max(v,0) : v, where v is mem[ptr] if written, else 0.
REQ-025 DRAIN: out_valid & out_ready advances ptr; out_data is held stable while out_ready=0.
REQ-026 DRAIN: the handshake at ptr=depth-1 moves the FSM to IDLE and pulses done for one cycle; out_valid drops the next cycle.
REQ-027 DRAIN: in_valid, acc_start and drain_start are ignored.
REQ-028 busy=1 exactly in ACCUM or DRAIN.

Reset
REQ-029 Reset forces, asynchronously: state=IDLE, ptr=0, all written flags=0, out_valid=0, done=0, busy=0, out_data=0.
REQ-030 mem contents are not reset; the written flags mask them.
REQ-031 Reset mid-ACCUM or mid-DRAIN abandons the tile; no done pulse is produced.

Structure
REQ-032 FSM state encoding and default psum_bw/depth shall live in the shared accel package/header.
REQ-033 The saturating signed adder shall be a sub-module, sat_add (parameter psum_bw).

Verification (psum_bw=16, depth=16)
REQ-034 acc_start; write addr3=10, then addr3=-4; drain_start with out_ready=1 -> 16 beats, beat3=6, all others 0, done one cycle after beat15.
REQ-035 Saturation:
- addr0: 32000 then 1000 -> drains 32767.
- addr1: -32000 then -1000 -> drains -32768.
REQ-036 relu_en=1; addr1=-5, addr2=7 -> drains 0 and 7; with relu_en=0 -> drains -5 and 7.
REQ-037 out_ready=0 for 3 cycles at ptr=2 (addr2=9) -> out_data=9 stable, ptr does not advance, total beats still 16.
REQ-038 in_valid addr0=4 in the same cycle as drain_start -> beat0=4.
REQ-039 reset asserted at ptr=5 -> out_valid=0 immediately, busy=0, no done; a later in_valid while in IDLE changes nothing.

Source files
------------

// File: rtl/psum_accum_pkg.sv
// ---------------------------------------------------------------------------
// psum_accum_pkg
//   Shared definitions for the partial-sum accumulator.
//   - PSUM_BW_DEFAULT : default width of a partial sum / drained value
//   - DEPTH_DEFAULT   : default number of accumulation entries
//   - state_e         : accumulator control states
// ---------------------------------------------------------------------------
package psum_accum_pkg;

  localparam int PSUM_BW_DEFAULT = 16;
  localparam int DEPTH_DEFAULT   = 16;

  // IDLE waits for a tile, ACCUM folds partial sums into the entries,
  // DRAIN streams every entry out through the valid/ready port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/psum_accum_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
//   Signed saturating adder. The sum is formed one bit wider than the
//   operands and clamped to the representable psum_bw-bit signed range.
//   Ports:
//     a_i   : signed operand (two's complement, psum_bw bits)
//     b_i   : signed operand (two's complement, psum_bw bits)
//     sum_o : saturated signed sum (psum_bw bits)
// ---------------------------------------------------------------------------
module sat_add
  import psum_accum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEFAULT
) (
  input  logic [psum_bw-1:0] a_i,
  input  logic [psum_bw-1:0] b_i,
  output logic [psum_bw-1:0] sum_o
);

  localparam logic [psum_bw-1:0] MAX_POS = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] MIN_NEG = {1'b1, {(psum_bw-1){1'b0}}};

  logic [psum_bw:0] wideSum;

  // Sign-extend both operands by one bit so the true sum always fits.
  assign wideSum = {a_i[psum_bw-1], a_i} + {b_i[psum_bw-1], b_i};

  // Overflow shows up as the top two bits of the wide sum disagreeing;
  // the top bit then tells which rail to clamp to.
  always_comb begin
    sum_o = wideSum[psum_bw-1:0];
    if (wideSum[psum_bw] != wideSum[psum_bw-1]) begin
      sum_o = wideSum[psum_bw] ? MIN_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/psum_accum.sv
// ---------------------------------------------------------------------------
// psum_accum
//   Accumulates signed partial sums from a MAC column into a small entry
//   memory, then drains every entry through a valid/ready output.
//   Ports:
//     clk         : clock, all state updates on the rising edge
//     reset       : asynchronous active-high reset
//     acc_start   : pulse, begins a new tile (invalidates all entries)
//     in_valid    : in_psum / in_addr valid this cycle
//     in_psum     : signed partial sum
//     in_addr     : target entry for in_psum
//     drain_start : pulse, ends accumulation and starts readout
//     relu_en     : clamp negative drained values to zero
//     out_data    : signed drained entry value
//     out_valid   : out_data is valid
//     out_ready   : consumer accepts out_data
//     busy        : high while accumulating or draining
//     done        : one-cycle pulse after the last drain handshake
// ---------------------------------------------------------------------------
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEFAULT,
  parameter int depth   = DEPTH_DEFAULT,
  parameter int aw      = $clog2(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               acc_start,
  input  logic               in_valid,
  input  logic [psum_bw-1:0] in_psum,
  input  logic [aw-1:0]      in_addr,
  input  logic               drain_start,
  input  logic               relu_en,
  output logic [psum_bw-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [aw-1:0] LAST_PTR = aw'(depth - 1);
  localparam logic [aw-1:0] ONE_PTR  = aw'(1);

  state_e             state_q;
  logic [aw-1:0]      ptr_q;
  logic [depth-1:0]   written_q;
  logic [psum_bw-1:0] outData_q;
  logic               outValid_q;
  logic               done_q;

  logic [psum_bw-1:0] mem [depth];

  logic               accumWrite;
  logic               drainEnter;
  logic               handshake;
  logic [psum_bw-1:0] oldVal;
  logic [psum_bw-1:0] sumVal;
  logic [aw-1:0]      loadAddr;
  logic [psum_bw-1:0] entryVal;
  logic [psum_bw-1:0] loadVal;

  // A write happens on any valid beat during ACCUM, including the beat that
  // coincides with drain_start. A re-issued acc_start opens a fresh tile, so
  // a beat arriving with it belongs to the abandoned tile and is dropped.
  assign accumWrite = (state_q == ACCUM) && in_valid && !acc_start;
  assign drainEnter = (state_q == ACCUM) && drain_start && !acc_start;
  assign handshake  = (state_q == DRAIN) && outValid_q && out_ready;

  // Unwritten entries read as zero, so the first beat simply stores in_psum.
  assign oldVal = written_q[in_addr] ? mem[in_addr] : '0;

  sat_add #(
    .psum_bw (psum_bw)
  ) u_sat_add (
    .a_i   (oldVal),
    .b_i   (in_psum),
    .sum_o (sumVal)
  );

  // The output register is loaded with the entry it is about to present:
  // entry 0 when the drain begins, otherwise the entry after the one just
  // accepted. On drain entry the same-cycle write to entry 0 is forwarded,
  // since the memory only reflects it after this edge. ReLU is applied at
  // load time so the presented value stays fixed while the consumer stalls.
  always_comb begin
    loadAddr = drainEnter ? '0 : (ptr_q + ONE_PTR);
    entryVal = '0;
    if (accumWrite && (in_addr == loadAddr)) begin
      entryVal = sumVal;
    end else if (written_q[loadAddr]) begin
      entryVal = mem[loadAddr];
    end
    loadVal = (relu_en && entryVal[psum_bw-1]) ? '0 : entryVal;
  end

  // Entry storage is deliberately not reset; the written flags mask stale
  // contents so a new tile never sees values from an older one.
  always_ff @(posedge clk) begin
    if (accumWrite) begin
      mem[in_addr] <= sumVal;
    end
  end

  // Control FSM with registered outputs. done is a single-cycle pulse, so
  // it is cleared every cycle unless the final handshake sets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      written_q  <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc_start) begin
            state_q   <= ACCUM;
            written_q <= '0;
          end
        end
        ACCUM: begin
          if (acc_start) begin
            written_q <= '0;
          end else begin
            if (accumWrite) begin
              written_q[in_addr] <= 1'b1;
            end
            if (drain_start) begin
              state_q    <= DRAIN;
              ptr_q      <= '0;
              outValid_q <= 1'b1;
              outData_q  <= loadVal;
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (ptr_q == LAST_PTR) begin
              state_q    <= IDLE;
              ptr_q      <= '0;
              outValid_q <= 1'b0;
              outData_q  <= '0;
              done_q     <= 1'b1;
            end else begin
              ptr_q     <= ptr_q + ONE_PTR;
              outData_q <= loadVal;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          ptr_q      <= '0;
          outValid_q <= 1'b0;
          outData_q  <= '0;
        end
      endcase
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_psum_accum.sv
// ---------------------------------------------------------------------------
// tb_psum_accum
//   Directed, table-driven bench for psum_accum (psum_bw=16, depth=16).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_psum_accum;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        acc_start;
  logic        in_valid;
  logic [15:0] in_psum;
  logic [3:0]  in_addr;
  logic        drain_start;
  logic        relu_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int compared;
  int mismatched;

  typedef struct {
    string name;
    int    addrA;
    int    valA;
    int    addrB;
    int    valB;
    bit    relu;
    int    expA;
    int    expB;
  } vec_t;

  vec_t vectors [7];

  psum_accum #(
    .psum_bw (16),
    .depth   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .acc_start   (acc_start),
    .in_valid    (in_valid),
    .in_psum     (in_psum),
    .in_addr     (in_addr),
    .drain_start (drain_start),
    .relu_en     (relu_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some wait never resolves.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pulseAccStart();
    acc_start = 1'b1;
    @(negedge clk);
    acc_start = 1'b0;
  endtask

  task automatic writeBeat(input int addr, input int val);
    in_valid = 1'b1;
    in_addr  = 4'(addr);
    in_psum  = 16'(val);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic startDrain();
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
  endtask

  // Walks a full drain from beat 0, optionally stalling at one pointer, and
  // checks every beat plus the done pulse and the return to idle.
  task automatic runDrain(input int expv [DEPTH], input int stallPtr,
                          input int stallCycles, input string tag);
    int beat;
    int cycles;
    int stallLeft;
    beat      = 0;
    cycles    = 0;
    stallLeft = stallCycles;
    while (beat < DEPTH && cycles < 200) begin
      checkOutput($sformatf("%s_valid%0d", tag, beat), int'(out_valid), 1);
      checkOutput($sformatf("%s_beat%0d", tag, beat), int'($signed(out_data)), expv[beat]);
      if (beat == stallPtr && stallLeft > 0) begin
        out_ready = 1'b0;
        stallLeft--;
      end else begin
        out_ready = 1'b1;
        beat++;
      end
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b1;
    checkOutput($sformatf("%s_beats_done", tag), beat, DEPTH);
    checkOutput($sformatf("%s_done_pulse", tag), int'(done), 1);
    checkOutput($sformatf("%s_valid_drop", tag), int'(out_valid), 0);
    @(negedge clk);
    checkOutput($sformatf("%s_done_clear", tag), int'(done), 0);
    checkOutput($sformatf("%s_busy_idle", tag), int'(busy), 0);
  endtask

  // One table record: new tile, two back-to-back writes, then a full drain.
  task automatic applyStimulus(input vec_t v);
    int expv [DEPTH];
    pulseAccStart();
    checkOutput({v.name, "_busy_accum"}, int'(busy), 1);
    writeBeat(v.addrA, v.valA);
    writeBeat(v.addrB, v.valB);
    relu_en = v.relu;
    for (int i = 0; i < DEPTH; i++) expv[i] = 0;
    expv[v.addrA] = v.expA;
    expv[v.addrB] = v.expB;
    startDrain();
    runDrain(expv, -1, 0, v.name);
    relu_en = 1'b0;
  endtask

  initial begin
    int expv [DEPTH];
    int doneSeen;

    compared    = 0;
    mismatched  = 0;
    reset       = 1'b1;
    acc_start   = 1'b0;
    in_valid    = 1'b0;
    in_psum     = '0;
    in_addr     = '0;
    drain_start = 1'b0;
    relu_en     = 1'b0;
    out_ready   = 1'b1;

    vectors[0] = '{"acc3",    3,  10,     3,  -4,    1'b0,      6,      6};
    vectors[1] = '{"satpos",  0,  32000,  0,  1000,  1'b0,  32767,  32767};
    vectors[2] = '{"satneg",  1, -32000,  1, -1000,  1'b0, -32768, -32768};
    vectors[3] = '{"relu_on", 1,  -5,     2,  7,     1'b1,      0,      7};
    vectors[4] = '{"relu_off",1,  -5,     2,  7,     1'b0,     -5,      7};
    vectors[5] = '{"relu_hi", 15, 100,    14, -200,  1'b1,    100,      0};
    vectors[6] = '{"minsat",  15, -32768, 15, -1,    1'b0, -32768, -32768};

    repeat (3) @(negedge clk);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_data", int'($signed(out_data)), 0);
    reset = 1'b0;
    @(negedge clk);

    // drain_start and in_valid in IDLE must not start anything
    drain_start = 1'b1;
    writeBeat(2, 55);
    drain_start = 1'b0;
    checkOutput("idle_ignore_busy", int'(busy), 0);
    checkOutput("idle_ignore_valid", int'(out_valid), 0);

    for (int k = 0; k < 7; k++) applyStimulus(vectors[k]);

    // Consumer stalls three cycles while entry 2 is presented
    pulseAccStart();
    writeBeat(2, 9);
    startDrain();
    for (int i = 0; i < DEPTH; i++) expv[i] = 0;
    expv[2] = 9;
    runDrain(expv, 2, 3, "stall");

    // Write to entry 0 in the same cycle as drain_start
    pulseAccStart();
    in_valid    = 1'b1;
    in_addr     = 4'd0;
    in_psum     = 16'd4;
    drain_start = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
    drain_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) expv[i] = 0;
    expv[0] = 4;
    runDrain(expv, -1, 0, "samecyc");

    // acc_start wins over drain_start and discards earlier writes
    pulseAccStart();
    writeBeat(4, 5);
    acc_start   = 1'b1;
    drain_start = 1'b1;
    @(negedge clk);
    acc_start   = 1'b0;
    drain_start = 1'b0;
    checkOutput("prio_busy", int'(busy), 1);
    checkOutput("prio_no_drain", int'(out_valid), 0);
    startDrain();
    for (int i = 0; i < DEPTH; i++) expv[i] = 0;
    runDrain(expv, -1, 0, "prio");

    // Reset in the middle of a drain at ptr 5
    pulseAccStart();
    writeBeat(5, 123);
    startDrain();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("prerst_beat5", int'($signed(out_data)), 123);
    reset = 1'b1;
    #1;
    checkOutput("midrst_valid", int'(out_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_data", int'($signed(out_data)), 0);
    checkOutput("midrst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("postrst_no_done", doneSeen, 0);
    writeBeat(3, 77);
    checkOutput("postrst_idle_busy", int'(busy), 0);
    checkOutput("postrst_idle_valid", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
